// File: rtl/state_setting_pkg.sv
// Shared constants for the kitchen-timer time-entry block: top-level state codes,
// BCD digit limits, blank-digit code and the local edit FSM encoding.
package state_setting_pkg;

  localparam logic [2:0] STATE_COUNTING = 3'd0;
  localparam logic [2:0] STATE_SETTING  = 3'd1;

  localparam logic [3:0] DIGIT_MAX   = 4'd9;
  localparam logic [3:0] SEC1_MAX    = 4'd5;
  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  typedef enum logic {
    SET_IDLE = 1'b0,
    SET_EDIT = 1'b1
  } set_state_t;

  // Cursor position 2 is the tens-of-seconds digit; all others run 0-9.
  function automatic logic [3:0] digit_limit(input logic [1:0] pos);
    return (pos == 2'd2) ? SEC1_MAX : DIGIT_MAX;
  endfunction

endpackage

// File: rtl/state_setting_bcd_wrap_step.sv
// Combinational single-digit BCD step: inc wraps max->0, dec wraps 0->max,
// both or neither leaves the digit unchanged.
module bcd_wrap_step
  import state_setting_pkg::*;
(
  input  logic [3:0] digit,
  input  logic [3:0] max,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] next
);

  always_comb begin
    next = digit;
    if (inc && !dec) begin
      next = (digit >= max) ? 4'd0 : digit + 4'd1;
    end else if (dec && !inc) begin
      // An out-of-range digit also lands on max so the value re-enters range.
      next = ((digit == 4'd0) || (digit > max)) ? max : digit - 4'd1;
    end
  end

endmodule

// File: rtl/state_setting.sv
// Digit-by-digit mm:ss editor; edits and commits are registered (visible one edge
// after the button edge), commit writes initialClockValue and pulses done together.
module state_setting
  import state_setting_pkg::*;
#(
  parameter logic [2:0]  stateID       = STATE_SETTING,
  parameter logic [15:0] DEFAULT_VALUE = 16'h0500,
  parameter int          BLINK_HALF    = 4
) (
  input  logic        slowclk,
  input  logic        reset,
  input  logic [2:0]  currentState,
  input  logic        btnNext,
  input  logic        btnInc,
  input  logic        btnDec,
  input  logic        btnConfirm,
  output logic [15:0] initialClockValue,
  output logic [15:0] digitsOut,
  output logic        done
);

  localparam int CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

  set_state_t       r_state;
  set_state_t       w_state_nxt;
  logic [15:0]      r_working;
  logic [15:0]      r_value;
  logic [1:0]       r_cursor;
  logic [CNT_W-1:0] r_blink_cnt;
  logic             r_blink_off;
  logic             r_done;
  logic             r_prev_next, r_prev_inc, r_prev_dec, r_prev_cfm;

  logic        w_active;
  logic        w_next_edge, w_inc_edge, w_dec_edge, w_cfm_edge;
  logic        w_load, w_commit, w_move, w_step;
  logic [15:0] w_stepped;
  logic [15:0] w_masked;

  assign w_active    = (currentState == stateID);
  assign w_next_edge = btnNext    & ~r_prev_next;
  assign w_inc_edge  = btnInc     & ~r_prev_inc;
  assign w_dec_edge  = btnDec     & ~r_prev_dec;
  assign w_cfm_edge  = btnConfirm & ~r_prev_cfm;

  // Cursor 0 (min1) is the most significant nibble.
  for (genvar i = 0; i < 4; i++) begin : g_digit
    localparam int LSB = 4 * (3 - i);
    bcd_wrap_step u_step (
      .digit (r_working[LSB +: 4]),
      .max   (digit_limit(2'(i))),
      .inc   (w_inc_edge & (r_cursor == 2'(i))),
      .dec   (w_dec_edge & (r_cursor == 2'(i))),
      .next  (w_stepped[LSB +: 4])
    );
  end

  always_ff @(posedge slowclk or posedge reset) begin
    if (reset) begin
      r_state <= SET_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Leaving the state wins over everything; then confirm > next > inc/dec.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    w_move      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      SET_IDLE: begin
        if (w_active) begin
          w_state_nxt = SET_EDIT;
          w_load      = 1'b1;
        end
      end
      SET_EDIT: begin
        if (!w_active) begin
          w_state_nxt = SET_IDLE;
        end else if (w_cfm_edge) begin
          if (r_working != 16'h0000) begin
            w_commit    = 1'b1;
            w_state_nxt = SET_IDLE;
          end
        end else if (w_next_edge) begin
          w_move = 1'b1;
        end else if (w_inc_edge || w_dec_edge) begin
          w_step = 1'b1;
        end
      end
      default: w_state_nxt = SET_IDLE;
    endcase
  end

  always_ff @(posedge slowclk or posedge reset) begin
    if (reset) begin
      r_working   <= DEFAULT_VALUE;
      r_value     <= DEFAULT_VALUE;
      r_cursor    <= 2'd0;
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
      r_done      <= 1'b0;
      r_prev_next <= 1'b0;
      r_prev_inc  <= 1'b0;
      r_prev_dec  <= 1'b0;
      r_prev_cfm  <= 1'b0;
    end else begin
      r_prev_next <= btnNext;
      r_prev_inc  <= btnInc;
      r_prev_dec  <= btnDec;
      r_prev_cfm  <= btnConfirm;
      r_done      <= w_commit;
      if (w_commit) begin
        r_value <= r_working;
      end
      if (w_load) begin
        r_working <= r_value;
        r_cursor  <= 2'd0;
      end else if (w_move) begin
        r_cursor <= r_cursor + 2'd1;
      end else if (w_step) begin
        r_working <= w_stepped;
      end
      // Any edit restarts the blink in the visible phase.
      if (w_load || w_move || w_step) begin
        r_blink_cnt <= '0;
        r_blink_off <= 1'b0;
      end else if (r_state == SET_EDIT) begin
        if (r_blink_cnt == CNT_LAST) begin
          r_blink_cnt <= '0;
          r_blink_off <= ~r_blink_off;
        end else begin
          r_blink_cnt <= r_blink_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_masked = r_working;
    if (r_blink_off) begin
      case (r_cursor)
        2'd0:    w_masked[15:12] = BLANK_DIGIT;
        2'd1:    w_masked[11:8]  = BLANK_DIGIT;
        2'd2:    w_masked[7:4]   = BLANK_DIGIT;
        default: w_masked[3:0]   = BLANK_DIGIT;
      endcase
    end
  end

  assign digitsOut         = (r_state == SET_EDIT) ? w_masked : r_value;
  assign initialClockValue = r_value;
  assign done              = r_done;

endmodule

// File: tb/tb_state_setting.sv
// Directed bench for state_setting: a vector table for the basic edit flow plus
// hand-written sequences for commit, rejection, abandon, held buttons and async reset.
module tb_state_setting;
  import state_setting_pkg::*;

  logic        slowclk;
  logic        reset;
  logic [2:0]  currentState;
  logic        btnNext, btnInc, btnDec, btnConfirm;
  logic [15:0] initialClockValue;
  logic [15:0] digitsOut;
  logic        done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int dc0;

  state_setting #(
    .stateID       (STATE_SETTING),
    .DEFAULT_VALUE (16'h0500),
    .BLINK_HALF    (4)
  ) dut (
    .slowclk           (slowclk),
    .reset             (reset),
    .currentState      (currentState),
    .btnNext           (btnNext),
    .btnInc            (btnInc),
    .btnDec            (btnDec),
    .btnConfirm        (btnConfirm),
    .initialClockValue (initialClockValue),
    .digitsOut         (digitsOut),
    .done              (done)
  );

  initial slowclk = 1'b0;
  always #5 slowclk = ~slowclk;

  always @(negedge slowclk) if (done === 1'b1) done_cnt++;

  typedef struct {
    logic [2:0]  st;
    logic        n, i, d, c;
    logic [15:0] dig;
    logic [15:0] icv;
    logic        dn;
  } vec_t;

  vec_t vt [0:31];

  function automatic vec_t mk(input logic [2:0] st, input logic n, input logic i,
                              input logic d, input logic c, input logic [15:0] dig,
                              input logic [15:0] icv, input logic dn);
    vec_t v;
    v.st = st; v.n = n; v.i = i; v.d = d; v.c = c;
    v.dig = dig; v.icv = icv; v.dn = dn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge slowclk);
    #1;
  endtask

  task automatic release_all;
    btnNext = 1'b0; btnInc = 1'b0; btnDec = 1'b0; btnConfirm = 1'b0;
  endtask

  // b: 0=next 1=inc 2=dec; each press is one high cycle then one low cycle.
  task automatic pulse(input int b, input int n);
    repeat (n) begin
      case (b)
        0:       btnNext = 1'b1;
        1:       btnInc  = 1'b1;
        default: btnDec  = 1'b1;
      endcase
      tick();
      release_all();
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    currentState = STATE_COUNTING;
    release_all();

    // Blink phase is on for 4 cycles after entry/edit, then off for 4.
    vt[0]  = mk(1, 0, 0, 0, 0, 16'h0500, 16'h0500, 0);
    vt[1]  = mk(1, 0, 0, 0, 0, 16'h0500, 16'h0500, 0);
    vt[2]  = mk(1, 0, 0, 0, 0, 16'h0500, 16'h0500, 0);
    vt[3]  = mk(1, 0, 0, 0, 0, 16'h0500, 16'h0500, 0);
    vt[4]  = mk(1, 0, 0, 0, 0, 16'hF500, 16'h0500, 0);
    vt[5]  = mk(1, 0, 0, 0, 0, 16'hF500, 16'h0500, 0);
    vt[6]  = mk(1, 0, 0, 0, 0, 16'hF500, 16'h0500, 0);
    vt[7]  = mk(1, 0, 0, 0, 0, 16'hF500, 16'h0500, 0);
    vt[8]  = mk(1, 0, 0, 0, 0, 16'h0500, 16'h0500, 0);
    vt[9]  = mk(1, 0, 0, 1, 0, 16'h9500, 16'h0500, 0);
    vt[10] = mk(1, 0, 0, 0, 0, 16'h9500, 16'h0500, 0);
    vt[11] = mk(1, 1, 0, 0, 0, 16'h9500, 16'h0500, 0);
    vt[12] = mk(1, 0, 0, 0, 0, 16'h9500, 16'h0500, 0);
    vt[13] = mk(1, 1, 0, 0, 0, 16'h9500, 16'h0500, 0);
    vt[14] = mk(1, 0, 0, 0, 0, 16'h9500, 16'h0500, 0);
    vt[15] = mk(1, 0, 0, 1, 0, 16'h9550, 16'h0500, 0);
    vt[16] = mk(1, 0, 0, 0, 0, 16'h9550, 16'h0500, 0);
    vt[17] = mk(1, 0, 1, 0, 0, 16'h9500, 16'h0500, 0);
    vt[18] = mk(1, 0, 0, 0, 0, 16'h9500, 16'h0500, 0);
    vt[19] = mk(1, 0, 0, 1, 0, 16'h9550, 16'h0500, 0);
    vt[20] = mk(1, 0, 0, 0, 0, 16'h9550, 16'h0500, 0);
    vt[21] = mk(1, 0, 0, 0, 0, 16'h9550, 16'h0500, 0);
    vt[22] = mk(1, 0, 0, 0, 0, 16'h9550, 16'h0500, 0);
    vt[23] = mk(1, 0, 0, 0, 0, 16'h95F0, 16'h0500, 0);
    vt[24] = mk(1, 0, 1, 1, 0, 16'h9550, 16'h0500, 0);
    vt[25] = mk(1, 0, 0, 0, 0, 16'h9550, 16'h0500, 0);
    vt[26] = mk(1, 1, 1, 0, 0, 16'h9550, 16'h0500, 0);
    vt[27] = mk(1, 0, 0, 0, 0, 16'h9550, 16'h0500, 0);
    vt[28] = mk(1, 0, 1, 0, 0, 16'h9551, 16'h0500, 0);
    vt[29] = mk(1, 0, 0, 0, 0, 16'h9551, 16'h0500, 0);
    vt[30] = mk(1, 0, 0, 0, 1, 16'h9551, 16'h9551, 1);
    vt[31] = mk(0, 0, 0, 0, 0, 16'h9551, 16'h9551, 0);

    tick();
    chk("reset_digits", digitsOut, 16'h0500);
    chk("reset_icv", initialClockValue, 16'h0500);
    chk("reset_done", {15'd0, done}, 16'd0);
    reset = 1'b0;
    tick();
    chk("idle_digits", digitsOut, 16'h0500);

    for (int k = 0; k < 32; k++) begin
      currentState = vt[k].st;
      btnNext = vt[k].n; btnInc = vt[k].i; btnDec = vt[k].d; btnConfirm = vt[k].c;
      tick();
      chk($sformatf("vec%0d_digits", k), digitsOut, vt[k].dig);
      chk($sformatf("vec%0d_icv", k), initialClockValue, vt[k].icv);
      chk($sformatf("vec%0d_done", k), {15'd0, done}, {15'd0, vt[k].dn});
    end
    release_all();

    // Edit 95:51 to 12:34 and commit.
    currentState = STATE_SETTING;
    tick();
    chk("seqA_entry", digitsOut, 16'h9551);
    pulse(1, 2); pulse(0, 1); pulse(2, 3); pulse(0, 1);
    pulse(2, 2); pulse(0, 1); pulse(1, 3);
    chk("seqA_working", digitsOut, 16'h1234);
    dc0 = done_cnt;
    btnConfirm = 1'b1;
    tick();
    chk("seqA_done_hi", {15'd0, done}, 16'd1);
    chk("seqA_icv", initialClockValue, 16'h1234);
    btnConfirm = 1'b0;
    tick();
    chk("seqA_done_lo", {15'd0, done}, 16'd0);
    chk("seqA_icv_hold", initialClockValue, 16'h1234);
    chk("seqA_reentry", digitsOut, 16'h1234);
    chk("seqA_done_cycles", 16'(done_cnt - dc0), 16'd1);

    // Drive working to 00:00; confirm must be rejected and stay in edit.
    pulse(2, 1); pulse(0, 1); pulse(2, 2); pulse(0, 1);
    pulse(2, 3); pulse(0, 1); pulse(2, 4);
    chk("seqB_zero", digitsOut, 16'h0000);
    btnConfirm = 1'b1;
    tick();
    chk("seqB_no_done", {15'd0, done}, 16'd0);
    chk("seqB_icv", initialClockValue, 16'h1234);
    chk("seqB_digits", digitsOut, 16'h0000);
    btnConfirm = 1'b0;
    tick();
    chk("seqB_digits2", digitsOut, 16'h0000);
    tick();
    chk("seqB_still_edit", digitsOut, 16'h000F);

    // Cursor wraps 3->0, edit to 07:00, then abandon and re-enter.
    pulse(0, 2); pulse(1, 7);
    chk("seqC_working", digitsOut, 16'h0700);
    currentState = STATE_COUNTING;
    tick();
    chk("seqC_idle", digitsOut, 16'h1234);
    chk("seqC_icv", initialClockValue, 16'h1234);
    currentState = STATE_SETTING;
    tick();
    chk("seqC_reload", digitsOut, 16'h1234);
    chk("seqC_no_done", 16'(done_cnt - dc0), 16'd1);

    // Inc held across entry produces no edge.
    currentState = STATE_COUNTING;
    tick();
    btnInc = 1'b1;
    tick();
    currentState = STATE_SETTING;
    tick();
    tick();
    chk("seqD_held_inc", digitsOut, 16'h1234);
    btnInc = 1'b0;
    tick();
    chk("seqD_release", digitsOut, 16'h1234);

    // Async reset between clock edges.
    pulse(1, 1);
    chk("seqE_edit", digitsOut, 16'h2234);
    #3;
    reset = 1'b1;
    #1;
    chk("seqE_rst_digits", digitsOut, 16'h0500);
    chk("seqE_rst_icv", initialClockValue, 16'h0500);
    chk("seqE_rst_done", {15'd0, done}, 16'd0);
    tick();
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
